// File: rtl/mmio_timer_pkg.sv
// mmio_timer shared types: FSM states, register offsets, CTRL fields.
// Imported by the timer top and its testbench.
package mmio_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  localparam logic [3:0] OFF_CTRL     = 4'h0;
  localparam logic [3:0] OFF_PRESET   = 4'h4;
  localparam logic [3:0] OFF_COUNT    = 4'h8;
  localparam logic [3:0] OFF_PRESCALE = 4'hC;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;

  localparam logic [1:0] MODE_AUTO = 2'd1;

  localparam logic [4:0] DEF_EXC_ADEL = 5'd4;
  localparam logic [4:0] DEF_EXC_ADES = 5'd5;

endpackage

// File: rtl/mmio_timer_if.sv
// CPU data-bus side of the memory-mapped timer.
// master = CPU/bridge, slave = timer.
interface mmio_timer_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic        rd_en;
  logic [1:0]  read_mode;
  logic        hit;
  logic [31:0] rdata;
  logic [4:0]  e_code;

  modport master (
    output addr, wdata, byteen,
    output rd_en, read_mode,
    input  hit, rdata, e_code
  );

  modport slave (
    input  addr, wdata, byteen,
    input  rd_en, read_mode,
    output hit, rdata, e_code
  );

endinterface

// File: rtl/mmio_timer_prescaler.sv
// Tick generator: o_tick once every i_div+1 running cycles.
// Used by mmio_timer only when TIMER_PRESCALE_EN is defined.
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_run,
  input  logic [7:0] i_div,
  output logic       o_tick
);

  logic [7:0] r_cnt;

  assign o_tick = (r_cnt == i_div);

  always_ff @(posedge clk) begin
    if (reset || i_clear)
      r_cnt <= '0;
    else if (i_run)
      r_cnt <= o_tick ? 8'd0 : r_cnt + 8'd1;
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with one interrupt line.
// Optional TIMER_PRESCALE_EN adds a PRESCALE register at +0xC.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter logic [4:0]  EXC_ADEL  = DEF_EXC_ADEL,
  parameter logic [4:0]  EXC_ADES  = DEF_EXC_ADES
) (
  input  logic         clk,
  input  logic         reset,
  mmio_timer_if.slave  bus,
  output logic         irq
);

  state_t      r_state;
  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic        r_flag;
  logic [31:0] r_preset;
  logic [31:0] r_count;

  logic [3:0]  w_off;
  logic        w_in_win;
  logic        w_st;
  logic        w_ld;
  logic        w_st_reg;
  logic        w_st_ok;
  logic        w_ld_ok;
  logic        w_wr_ctrl;
  logic        w_wr_pre;
  logic        w_auto;
  logic        w_tick;
  logic [31:0] w_rsel;

  assign w_off    = bus.addr[3:0];
  assign w_in_win = bus.addr[31:4] == BASE_ADDR[31:4];
  assign w_st     = w_in_win && (bus.byteen != 4'h0);
  assign w_ld     = w_in_win && bus.rd_en;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] r_prescale;
  logic       w_wr_ps;

  assign w_st_reg = (w_off == OFF_CTRL) ||
                    (w_off == OFF_PRESET) ||
                    (w_off == OFF_PRESCALE);
  assign w_wr_ps  = w_st_ok && (w_off == OFF_PRESCALE);

  always_ff @(posedge clk) begin
    if (reset)
      r_prescale <= '0;
    else if (w_wr_ps)
      r_prescale <= bus.wdata[7:0];
  end

  timer_prescaler u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_state == LOAD),
    .i_run   (r_state == CNT),
    .i_div   (r_prescale),
    .o_tick  (w_tick)
  );
`else
  assign w_st_reg = (w_off == OFF_CTRL) ||
                    (w_off == OFF_PRESET);
  assign w_tick   = 1'b1;
`endif

  // full 4-bit offset compare also enforces word alignment
  assign w_st_ok   = w_st && (bus.byteen == 4'hF) && w_st_reg;
  assign w_ld_ok   = w_ld && (bus.addr[1:0] == 2'b00) &&
                     (bus.read_mode == 2'd0);
  assign w_wr_ctrl = w_st_ok && (w_off == OFF_CTRL);
  assign w_wr_pre  = w_st_ok && (w_off == OFF_PRESET);
  assign w_auto    = (r_mode == MODE_AUTO);

  assign bus.hit = w_in_win &&
                   (bus.rd_en || (bus.byteen != 4'h0));

  assign bus.e_code = (w_st && !w_st_ok) ? EXC_ADES :
                      (w_ld && !w_ld_ok) ? EXC_ADEL :
                      5'd0;

  always_comb begin
    w_rsel = '0;
    unique case (1'b1)
      w_off[3:2] == 2'd0:
        w_rsel = {28'd0, r_im, r_mode, r_en};
      w_off[3:2] == 2'd1:
        w_rsel = r_preset;
      w_off[3:2] == 2'd2:
        w_rsel = r_count;
      w_off[3:2] == 2'd3:
`ifdef TIMER_PRESCALE_EN
        w_rsel = {24'd0, r_prescale};
`else
        w_rsel = '0;
`endif
    endcase
  end

  assign bus.rdata = w_ld_ok ? w_rsel : 32'd0;
  assign irq       = r_im & r_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_en     <= 1'b0;
      r_mode   <= 2'd0;
      r_im     <= 1'b0;
      r_flag   <= 1'b0;
      r_preset <= '0;
      r_count  <= '0;
    end else begin
      if (r_flag && w_auto)
        r_flag <= 1'b0;
      if (w_wr_ctrl) begin
        r_en   <= bus.wdata[CTRL_EN];
        r_mode <= bus.wdata[CTRL_MODE +: 2];
        r_im   <= bus.wdata[CTRL_IM];
        r_flag <= 1'b0;
      end
      if (w_wr_pre)
        r_preset <= bus.wdata;
      unique case (r_state)
        IDLE:
          if (r_en) r_state <= LOAD;
        LOAD: begin
          r_count <= r_preset;
          r_state <= CNT;
        end
        CNT:
          if (!r_en)
            r_state <= IDLE;
          else if (r_count != '0) begin
            if (w_tick) r_count <= r_count - 32'd1;
          end else
            r_state <= INT;
        // a CTRL store this cycle owns EN and the flag
        INT: begin
          if (!w_wr_ctrl) begin
            r_flag <= 1'b1;
            if (!w_auto) r_en <= 1'b0;
          end
          r_state <= w_auto ? LOAD : IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Randomized self-checking bench for mmio_timer.
// Expected values come from the timer's latency arithmetic.
module tb_mmio_timer;
  import mmio_timer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef TIMER_PRESCALE_EN
  localparam bit HAS_PS = 1'b1;
`else
  localparam bit HAS_PS = 1'b0;
`endif

  logic clk;
  logic reset;
  logic irq;

  mmio_timer_if bus();

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [7:0]  m_ps;

  logic [31:0] v;
  int n, p, s, hold;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.byteen    = '0;
    bus.rd_en     = 1'b0;
    bus.read_mode = 2'd0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] off,
                    input logic [31:0] d);
    bus.addr   = BASE | {28'd0, off};
    bus.wdata  = d;
    bus.byteen = 4'hF;
    bus.rd_en  = 1'b0;
    step();
    bus_idle();
  endtask

  task automatic rd(input logic [3:0] off,
                    output logic [31:0] d);
    bus.addr      = BASE | {28'd0, off};
    bus.byteen    = 4'h0;
    bus.rd_en     = 1'b1;
    bus.read_mode = 2'd0;
    #1;
    d = bus.rdata;
    bus_idle();
  endtask

  // COUNT k cycles after the EN edge, div = prescale value
  function automatic int cnt_at(int nn, int k, int div);
    int j;
    j = (k - 2) / (div + 1);
    return (j >= nn) ? 0 : nn - j;
  endfunction

  function automatic logic [31:0] regval(logic [1:0] sel);
    case (sel)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return 32'd0;
      default: return HAS_PS ? {24'd0, m_ps} : 32'd0;
    endcase
  endfunction

  task automatic vec(input logic [31:0] a,
                     input logic [3:0] be,
                     input logic re,
                     input logic [1:0] rm);
    logic inwin, st_ok, ld_ok;
    logic [4:0]  ee;
    logic [31:0] er;
    bus.addr      = a;
    bus.wdata     = $urandom;
    bus.byteen    = be;
    bus.rd_en     = re;
    bus.read_mode = rm;
    inwin = a[31:4] == BASE[31:4];
    st_ok = (be == 4'hF) &&
            (a[3:0] == 4'h0 || a[3:0] == 4'h4 ||
             (HAS_PS && a[3:0] == 4'hC));
    ld_ok = (a[1:0] == 2'b00) && (rm == 2'd0);
    ee = 5'd0;
    if (inwin && be != 4'h0 && !st_ok)
      ee = 5'd5;
    else if (inwin && re && !ld_ok)
      ee = 5'd4;
    er = (inwin && re && ld_ok) ? regval(a[3:2]) : 32'd0;
    #1;
    check("dec.hit", bus.hit,
          inwin && (re || be != 4'h0));
    check("dec.ecode", bus.e_code, ee);
    check("dec.rdata", bus.rdata, er);
    // legal stores are withdrawn so state stays known
    if (inwin && be != 4'h0 && st_ok)
      bus_idle();
    step();
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    logic        re;
    logic [1:0]  rm;
    n_vec = 0;
    n_bad = 0;
    m_ps  = 8'd0;
    bus_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // reset state
    rd(OFF_CTRL, v);   check("rst.ctrl", v, 0);
    rd(OFF_PRESET, v); check("rst.preset", v, 0);
    rd(OFF_COUNT, v);  check("rst.count", v, 0);
    check("rst.irq", irq, 0);
    check("rst.ecode", bus.e_code, 0);

    // one-shot with interrupt mask set
    n = $urandom_range(1, 10);
    wr(OFF_PRESET, n);
    wr(OFF_CTRL, 32'h9);
    for (int k = 1; k <= n + 6; k++) begin
      step();
      rd(OFF_COUNT, v);
      if (k >= 2) check("os.count", v, cnt_at(n, k, 0));
      check("os.irq", irq, k >= n + 4);
    end
    rd(OFF_CTRL, v); check("os.ctrl", v, 32'h8);
    check("os.irq_hold", irq, 1);
    wr(OFF_CTRL, 0);
    check("os.irq_clr", irq, 0);

    // auto-reload: pulse every n+3 cycles
    n = $urandom_range(0, 6);
    p = n + 3;
    wr(OFF_PRESET, n);
    wr(OFF_CTRL, 32'hB);
    for (int k = 1; k <= 3 * p + 3; k++) begin
      int r;
      step();
      rd(OFF_COUNT, v);
      r = (k - 2) % p;
      if (k >= 2) begin
        check("ar.count", v, (r <= n) ? n - r : 0);
        check("ar.irq", irq, r == n + 2);
      end else
        check("ar.irq0", irq, 0);
    end
    wr(OFF_CTRL, 0);
    repeat (4) step();
    check("ar.stop_irq", irq, 0);

    // address decode and legality
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_preset = $urandom;
    wr(OFF_PRESET, m_preset);
    v = $urandom & 32'hFFFF_FFFE;
    wr(OFF_CTRL, v);
    m_ctrl = v[3:0];
    rd(OFF_CTRL, v); check("ctrl.mask", v, {28'd0, m_ctrl});
    vec(BASE + 32'h8, 4'hF, 1'b0, 2'd0);
    vec(BASE + 32'h4, 4'h3, 1'b0, 2'd0);
    vec(BASE + 32'h1, 4'hF, 1'b0, 2'd0);
    vec(BASE + 32'h4, 4'h0, 1'b1, 2'd2);
    vec(BASE + 32'hC, 4'h0, 1'b1, 2'd0);
    vec(BASE + 32'hC, 4'hF, 1'b0, 2'd0);
    vec(BASE + 32'h10, 4'hF, 1'b0, 2'd0);
    vec(BASE - 32'h4, 4'h0, 1'b1, 2'd0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        a = BASE | 32'($urandom_range(0, 15));
      else
        a = $urandom;
      case ($urandom_range(0, 5))
        0: be = 4'h0;
        1: be = 4'hF;
        2: be = 4'h3;
        3: be = 4'hC;
        4: be = 4'h1;
        default: be = 4'h0;
      endcase
      re = (be == 4'h0) ? 1'($urandom_range(0, 1)) : 1'b0;
      rm = ($urandom_range(0, 1) == 1) ?
           2'd0 : 2'($urandom_range(1, 2));
      vec(a, be, re, rm);
    end
    rd(OFF_PRESET, v); check("dec.keep_pre", v, m_preset);
    rd(OFF_CTRL, v);   check("dec.keep_ctrl", v, {28'd0, m_ctrl});
    rd(OFF_COUNT, v);  check("dec.keep_cnt", v, 0);

    // pause mid-count, then restart reloads PRESET
    n = $urandom_range(30, 60);
    s = $urandom_range(3, n - 5);
    wr(OFF_PRESET, n);
    wr(OFF_CTRL, 32'h1);
    for (int k = 1; k <= s; k++) begin
      step();
      rd(OFF_COUNT, v);
      if (k >= 2) check("pz.count", v, cnt_at(n, k, 0));
    end
    wr(OFF_CTRL, 0);
    hold = cnt_at(n, s + 1, 0);
    repeat (4) begin
      step();
      rd(OFF_COUNT, v); check("pz.hold", v, hold);
    end
    wr(OFF_CTRL, 32'h1);
    step();
    rd(OFF_COUNT, v); check("pz.pre_load", v, hold);
    step();
    rd(OFF_COUNT, v); check("pz.reload", v, n);
    wr(OFF_CTRL, 0);
    repeat (3) step();

    // reset with irq high, and reset mid-count
    n = $urandom_range(1, 5);
    wr(OFF_PRESET, n);
    wr(OFF_CTRL, 32'h9);
    repeat (n + 5) step();
    check("rs.irq_up", irq, 1);
    reset = 1'b1;
    step();
    check("rs.irq_drop", irq, 0);
    reset = 1'b0;
    rd(OFF_CTRL, v);   check("rs.ctrl", v, 0);
    rd(OFF_PRESET, v); check("rs.preset", v, 0);
    rd(OFF_COUNT, v);  check("rs.count", v, 0);
    wr(OFF_PRESET, 40);
    wr(OFF_CTRL, 32'h1);
    repeat (25) step();
    rd(OFF_COUNT, v); check("rs.mid", v, 17);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd(OFF_COUNT, v); check("rs.mid_cnt", v, 0);
    repeat (3) step();
    rd(OFF_COUNT, v); check("rs.idle_cnt", v, 0);
    check("rs.idle_irq", irq, 0);

`ifdef TIMER_PRESCALE_EN
    wr(OFF_PRESCALE, 3);
    m_ps = 8'd3;
    rd(OFF_PRESCALE, v); check("ps.reg", v, 3);
    wr(OFF_PRESET, 2);
    wr(OFF_CTRL, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      step();
      rd(OFF_COUNT, v);
      if (k >= 2) check("ps.count", v, cnt_at(2, k, 3));
    end
    wr(OFF_CTRL, 0);
`else
    m_ctrl   = 4'h0;
    m_preset = 32'd0;
    vec(BASE + 32'hC, 4'hF, 1'b0, 2'd0);
    vec(BASE + 32'hC, 4'h0, 1'b1, 2'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
